ofifo: RTL and testbench

- Output FIFO directly downstream of the systolic MAC array; consumes the array's south-edge partial sums (out_s) and per-column valid strobes.
- Columns emit results on staggered cycles (diagonal wavefront), so each column has its own FIFO.
- A full output row is released only when every column holds at least one entry, re-aligning the skewed results into one row-wide word for the downstream SRAM/writeback stage.

---
 rtl/ofifo_pkg.sv | 8 +
 rtl/ofifo_col.sv | 47 ++++
 rtl/ofifo.sv | 56 +++++
 tb/tb_ofifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_pkg.sv
// Shared array geometry and the partial-sum word type for the MAC array, L0 buffer and ofifo.
package ofifo_pkg;
  localparam int ARRAY_COL   = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  typedef logic [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/ofifo_col.sv
// Single-column first-word-fall-through FIFO; head visible combinationally, write-to-not-empty one edge.
// A write to a full column is dropped (drop=1) unless the same edge pops, which frees the slot.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out,
  output logic          empty,
  output logic          full,
  output logic          drop
);
  localparam int aw = $clog2(depth);

  logic [bw-1:0] mem [depth];
  logic [aw:0]   wptr;
  logic [aw:0]   rptr;
  logic          wr_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  // rd is already qualified by the parent, so a pop here always frees a slot.
  assign wr_ok = wr && (!full || rd);
  assign drop  = wr && full && !rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd)    rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[aw-1:0]] <= in;
  end

  assign out = mem[rptr[aw-1:0]];
endmodule

// File: rtl/ofifo.sv
// Per-column output FIFOs re-aligning the skewed array wavefront into whole rows; o_valid one edge after last write.
// Rows pop only when every column holds data; o_ready=0 when any column is full, and dropped writes set sticky overflow.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = ARRAY_COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);
  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         drop;
  logic [psum_bw*col-1:0] head;
  logic                   pop;

  // A pop is all-or-nothing across columns so a row is never torn.
  assign pop = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(
      .bw    (psum_bw),
      .depth (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .rd    (pop),
      .in    (in[psum_bw*c +: psum_bw]),
      .out   (head[psum_bw*c +: psum_bw]),
      .empty (empty[c]),
      .full  (full[c]),
      .drop  (drop[c])
    );
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign out     = o_valid ? head : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      overflow <= 1'b0;
    else if (|drop) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_ofifo.sv
// Directed and randomized checks of ofifo against a per-column queue model.
module tb_ofifo;
  import ofifo_pkg::*;

  localparam int COL = ARRAY_COL;
  localparam int BW  = PSUM_BW;
  localparam int DEP = OFIFO_DEPTH;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [BW*COL-1:0] din = '0;
  logic [COL-1:0]    wr = '0;
  logic              rd = 1'b0;
  logic [BW*COL-1:0] out;
  logic              o_valid, o_full, o_ready, overflow;

  int n_total = 0;
  int n_pass  = 0;

  psum_t q [COL][$];
  logic  m_ovf = 1'b0;

  ofifo dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .wr       (wr),
    .rd       (rd),
    .out      (out),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW*COL-1:0] got, input logic [BW*COL-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic m_valid();
    for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COL; c++) if (q[c].size() == DEP) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < COL; c++) q[c].delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [BW*COL-1:0] exp_out;
    exp_out = '0;
    if (m_valid())
      for (int c = 0; c < COL; c++) exp_out[c*BW +: BW] = q[c][0];
    chk({tag, ".o_valid"},  {127'd0, o_valid},  {127'd0, m_valid()});
    chk({tag, ".o_full"},   {127'd0, o_full},   {127'd0, m_full()});
    chk({tag, ".o_ready"},  {127'd0, o_ready},  {127'd0, !m_full()});
    chk({tag, ".overflow"}, {127'd0, overflow}, {127'd0, m_ovf});
    chk({tag, ".out"},      out,                exp_out);
  endtask

  // Applies the current inputs to the model, clocks the DUT, then compares.
  task automatic cycle(input string tag);
    logic pop;
    if (reset) begin
      m_clear();
    end else begin
      pop = rd && m_valid();
      for (int c = 0; c < COL; c++) begin
        if (pop) void'(q[c].pop_front());
        if (wr[c]) begin
          if (q[c].size() < DEP) q[c].push_back(din[c*BW +: BW]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle("reset");
    reset = 1'b0;
  endtask

  task automatic rand_row();
    for (int c = 0; c < COL; c++) din[c*BW +: BW] = BW'($urandom);
  endtask

  initial begin
    logic [BW*COL-1:0] row;

    // Reset state
    #2;
    check_outputs("rst_async");
    cycle("rst_hold");
    reset = 1'b0;
    cycle("rst_idle");

    // Skewed diagonal fill
    for (int c = 0; c < COL; c++) begin
      wr = '0;
      wr[c] = 1'b1;
      din = '0;
      din[c*BW +: BW] = 16'h0100 + BW'(c);
      cycle("skew");
      chk("skew.valid", {127'd0, o_valid}, {127'd0, (c == COL - 1)});
    end
    idle();
    for (int c = 0; c < COL; c++) row[c*BW +: BW] = 16'h0100 + BW'(c);
    chk("skew.row", out, row);
    rd = 1'b1;
    cycle("skew_pop");
    chk("skew.drained", {127'd0, o_valid}, 128'd0);

    // Streaming: 100 staggered rows with rd held high
    rd = 1'b1;
    for (int t = 0; t < 100 + COL + 2; t++) begin
      for (int c = 0; c < COL; c++) wr[c] = (t - c >= 0) && (t - c < 100);
      rand_row();
      cycle("stream");
    end
    idle();
    chk("stream.ovf", {127'd0, overflow}, 128'd0);

    // Full boundary and dropped write
    for (int r = 0; r < DEP; r++) begin
      wr = '1;
      rand_row();
      cycle("fill");
    end
    idle();
    chk("fill.full", {127'd0, o_full}, 128'd1);
    chk("fill.ready", {127'd0, o_ready}, 128'd0);
    wr = 8'h08;
    rand_row();
    cycle("drop");
    chk("drop.ovf", {127'd0, overflow}, 128'd1);
    idle();
    rd = 1'b1;
    for (int r = 0; r < DEP; r++) cycle("drain");
    chk("drain.empty", {127'd0, o_valid}, 128'd0);
    do_reset();

    // Simultaneous read/write while full
    for (int r = 0; r < DEP; r++) begin
      wr = '1;
      rand_row();
      cycle("fill2");
    end
    wr = '1;
    rd = 1'b1;
    for (int c = 0; c < COL; c++) din[c*BW +: BW] = 16'hBEEF;
    cycle("rw_full");
    chk("rw_full.full", {127'd0, o_full}, 128'd1);
    chk("rw_full.ovf", {127'd0, overflow}, 128'd0);
    idle();
    rd = 1'b1;
    for (int r = 0; r < DEP - 1; r++) cycle("rw_drain");
    chk("rw_full.beef", out, {COL{16'hBEEF}});
    cycle("rw_last");
    idle();

    // Premature read with column 7 empty
    wr = 8'h7F;
    for (int c = 0; c < COL; c++) din[c*BW +: BW] = 16'h00A0 + BW'(c);
    cycle("pre_wr");
    wr = '0;
    rd = 1'b1;
    cycle("pre_rd");
    chk("pre.valid", {127'd0, o_valid}, 128'd0);
    rd = 1'b0;
    wr = 8'h80;
    cycle("pre_fill7");
    chk("pre.col0", {112'd0, out[BW-1:0]}, {112'd0, 16'h00A0});
    chk("pre.ovf", {127'd0, overflow}, 128'd0);
    idle();
    do_reset();

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      wr = COL'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      rand_row();
      cycle("rand");
    end
    idle();

    // Mid-run reset with 5 rows held
    do_reset();
    for (int r = 0; r < 5; r++) begin
      wr = '1;
      rand_row();
      cycle("hold5");
    end
    idle();
    chk("hold5.valid", {127'd0, o_valid}, 128'd1);
    reset = 1'b1;
    #1;
    m_clear();
    check_outputs("mid_rst");
    cycle("mid_rst_hold");
    reset = 1'b0;
    rd = 1'b1;
    cycle("post_rst_rd");
    rd = 1'b0;
    wr = '1;
    rand_row();
    cycle("post_rst_wr");
    idle();
    cycle("post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
